instruction_mem_sync: RTL and testbench
=======================================

INSTRUCTION_MEM_SYNC -- requirements
Module: instruction_mem_sync

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, instruction width; DEPTH, default 32, words of storage; ADDR_W, default 5, word-index width (2**ADDR_W == DEPTH).
REQ-002 The block SHALL use one clock, clk, and one reset, reset, which is synchronous and active-high.
REQ-003 Ports SHALL be, in order:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- pc  in  32  byte address of the fetch (the PC)
- stall  in  1  hold the current output
- flush  in  1  replace the next output with a NOP
- load_valid  in  1  load_data is valid this cycle
- load_data  in  DATA_W  program word to store
- load_last  in  1  qualifies load_valid: final program word
- reload  in  1  abandon RUN and restart program load
- instr  out  DATA_W  registered instruction
- instr_valid  out  1  instr holds a fetched word
- addr_err  out  1  the fetch this cycle was out of range or misaligned
- run  out  1  state == RUN
- prog_words  out  ADDR_W+1  number of words loaded

Function
REQ-004 FSM SHALL have two states: LOAD (entered on reset) and RUN.
REQ-005 In LOAD, each cycle with load_valid=1 SHALL write load_data to mem[wptr] and increment wptr and prog_words.
REQ-006 load_valid with load_last=1 SHALL write the word and enter RUN on the next cycle.
REQ-007 A write at wptr==DEPTH-1 SHALL be treated as the last word: enter RUN with prog_words=DEPTH, and never wrap wptr.
REQ-008 In RUN, load_valid SHALL be ignored (no write, no counter change).
REQ-009 reload=1 in either state SHALL set state=LOAD, wptr=0 and prog_words=0 next cycle, without altering memory contents; reload takes priority over load_valid in the same cycle.
REQ-010 Word index SHALL be pc[ADDR_W+1:2]; a fetch is in range iff pc[1:0]==0, pc[31:ADDR_W+2]==0 and index < prog_words.
REQ-011 Fetch latency SHALL be 1 cycle: in RUN with stall=0 and flush=0, on the next edge instr<=mem[index], instr_valid<=1 and addr_err<=0 if in range; else instr<=0 (NOP), instr_valid<=0, addr_err<=1.
REQ-012 stall=1 (flush=0) in RUN SHALL hold instr, instr_valid and addr_err unchanged.
REQ-013 flush=1 SHALL, on the next edge, set instr=0, instr_valid=0 and addr_err=0 regardless of stall; flush has priority over stall.
REQ-014 In LOAD, and on the edge that enters LOAD, the outputs SHALL be instr=0, instr_valid=0 and addr_err=0; stall and flush have no effect.
REQ-015 On the first cycle in RUN, outputs SHALL still be NOP/invalid; the first fetch is sampled on that cycle and appears one cycle later.
REQ-016 run SHALL be a combinational decode of state.
REQ-017 Memory SHALL be write-only from the load port and read-only from the fetch path; no read-during-write can occur because load and fetch are state-exclusive.

Reset
REQ-018 reset=1 SHALL, on the next edge, set state=LOAD, wptr=0, prog_words=0, instr=0, instr_valid=0, addr_err=0 and run=0, overriding all other inputs.
REQ-019 Reset SHALL NOT clear memory; simulation initial contents are all-zero.
REQ-020 Reset mid-load SHALL discard the load progress (prog_words=0), while words already written remain in memory.

Verification (DEPTH=32, DATA_W=32)
REQ-021 Load 0x00221821, 0x00000000, 0x8C430004 (last on 3rd); then pc=0,4,8 with no stall -> instr=0x00221821, 0, 0x8C430004 each one cycle after its pc, instr_valid=1, prog_words=3.
REQ-022 After REQ-021: pc=12 -> instr=0, instr_valid=0, addr_err=1; pc=2 -> addr_err=1; pc=0x80 -> addr_err=1.
REQ-023 Hold pc=4 then stall=1 while pc changes to 8 -> instr holds 0x00000000 with valid=1; assert flush and stall together -> next instr=0, instr_valid=0.
REQ-024 Load 32 words 0..31 with load_last never set -> run=1 after the 32nd write, prog_words=32; a 33rd load_valid -> no write; pc=124 -> instr=31.
REQ-025 In RUN, pulse reload with load_valid=1 -> state=LOAD, prog_words=0, and no write that cycle; load 1 word with last -> pc=0 returns the new word.
REQ-026 Assert reset after 2 load writes -> all outputs 0 and run=0 next cycle; reload 2 words with last, then pc=4 returns the newly written word 1.

Source files
------------

// File: rtl/instruction_mem_sync.sv
// Program-loadable instruction memory with a one-cycle registered fetch port.
// The program is streamed in during LOAD, then fetched by byte PC during RUN.
module instruction_mem_sync #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc,
  input  logic              stall,
  input  logic              flush,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              reload,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              addr_err,
  output logic              run,
  output logic [ADDR_W:0]   prog_words
);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state_reg;
  logic [ADDR_W-1:0] wptr_reg;
  logic [ADDR_W:0]   prog_words_reg;
  logic [DATA_W-1:0] instr_reg;
  logic              instr_valid_reg;
  logic              addr_err_reg;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] fetch_idx;
  logic              in_range;
  logic              load_en;
  logic              wptr_at_end;

  assign fetch_idx   = pc[ADDR_W+1:2];
  assign in_range    = (pc[1:0] == 2'b00) && (pc[31:ADDR_W+2] == '0) &&
                       ({1'b0, fetch_idx} < prog_words_reg);
  assign wptr_at_end = (wptr_reg == ADDR_W'(DEPTH - 1));
  assign load_en     = !reset && (state_reg == ST_LOAD) && load_valid && !reload;

  // Memory has no reset: reset and reload only discard load progress.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[wptr_reg] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_LOAD;
      wptr_reg        <= '0;
      prog_words_reg  <= '0;
      instr_reg       <= '0;
      instr_valid_reg <= 1'b0;
      addr_err_reg    <= 1'b0;
    end else if (state_reg == ST_LOAD) begin
      instr_reg       <= '0;
      instr_valid_reg <= 1'b0;
      addr_err_reg    <= 1'b0;
      if (reload) begin
        wptr_reg       <= '0;
        prog_words_reg <= '0;
      end else if (load_valid) begin
        prog_words_reg <= prog_words_reg + 1'b1;
        // The final slot forces RUN so the write pointer never wraps.
        if (load_last || wptr_at_end) begin
          state_reg <= ST_RUN;
        end else begin
          wptr_reg <= wptr_reg + 1'b1;
        end
      end
    end else begin
      if (reload) begin
        state_reg       <= ST_LOAD;
        wptr_reg        <= '0;
        prog_words_reg  <= '0;
        instr_reg       <= '0;
        instr_valid_reg <= 1'b0;
        addr_err_reg    <= 1'b0;
      end else if (flush) begin
        instr_reg       <= '0;
        instr_valid_reg <= 1'b0;
        addr_err_reg    <= 1'b0;
      end else if (!stall) begin
        if (in_range) begin
          instr_reg       <= mem[fetch_idx];
          instr_valid_reg <= 1'b1;
          addr_err_reg    <= 1'b0;
        end else begin
          instr_reg       <= '0;
          instr_valid_reg <= 1'b0;
          addr_err_reg    <= 1'b1;
        end
      end
    end
  end

  assign instr       = instr_reg;
  assign instr_valid = instr_valid_reg;
  assign addr_err    = addr_err_reg;
  assign prog_words  = prog_words_reg;
  assign run         = (state_reg == ST_RUN);

endmodule

// File: tb/tb_instruction_mem_sync.sv
// Randomized and directed bench for instruction_mem_sync, checked every cycle
// against a behavioural model of the program-load / fetch rules.
module tb_instruction_mem_sync;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        stall;
  logic        flush;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        reload;
  logic [31:0] instr;
  logic        instr_valid;
  logic        addr_err;
  logic        run;
  logic [5:0]  prog_words;

  instruction_mem_sync #(.DATA_W(32), .DEPTH(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .pc(pc), .stall(stall), .flush(flush),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .reload(reload), .instr(instr), .instr_valid(instr_valid),
    .addr_err(addr_err), .run(run), .prog_words(prog_words)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int check_cnt = 0;

  // Reference model state
  int unsigned m_mem [32];
  bit          m_run;
  int          m_wptr;
  int          m_words;
  int unsigned m_instr;
  bit          m_valid;
  bit          m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic model_clear_out();
    m_instr = 0; m_valid = 0; m_err = 0;
  endtask

  // Next-state of the model from the inputs present before the edge.
  task automatic model_step();
    int idx;
    if (reset) begin
      m_run = 0; m_wptr = 0; m_words = 0; model_clear_out();
    end else if (!m_run) begin
      model_clear_out();
      if (reload) begin
        m_wptr = 0; m_words = 0;
      end else if (load_valid) begin
        m_mem[m_wptr] = load_data;
        m_words++;
        if (load_last || m_wptr == 31) m_run = 1;
        else m_wptr++;
      end
    end else if (reload) begin
      m_run = 0; m_wptr = 0; m_words = 0; model_clear_out();
    end else if (flush) begin
      model_clear_out();
    end else if (!stall) begin
      idx = int'(pc / 4) % 32;
      if (pc % 4 == 0 && pc < 128 && idx < m_words) begin
        m_instr = m_mem[idx]; m_valid = 1; m_err = 0;
      end else begin
        m_instr = 0; m_valid = 0; m_err = 1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("instr", instr, m_instr);
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    check("addr_err", 32'(addr_err), 32'(m_err));
    check("run", 32'(run), 32'(m_run));
    check("prog_words", 32'(prog_words), 32'(m_words));
  endtask

  task automatic idle();
    reset = 0; stall = 0; flush = 0; load_valid = 0; load_last = 0;
    reload = 0; load_data = 0; pc = 0;
  endtask

  task automatic load_word(input logic [31:0] d, input bit last);
    idle(); load_valid = 1; load_data = d; load_last = last; tick();
  endtask

  task automatic fetch(input logic [31:0] a);
    idle(); pc = a; tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = 0;
    m_run = 0; m_wptr = 0; m_words = 0; model_clear_out();
    idle();
    reset = 1;
    // Random junk on other inputs during reset must be overridden.
    load_valid = 1; load_data = 32'hFFFF_FFFF; flush = 1;
    tick(); tick();
    check("reset_run", 32'(run), 32'd0);
    check("reset_words", 32'(prog_words), 32'd0);

    // Three-word program, then fetches.
    load_word(32'h00221821, 0);
    load_word(32'h00000000, 0);
    load_word(32'h8C430004, 1);
    check("load3_run", 32'(run), 32'd1);
    check("load3_words", 32'(prog_words), 32'd3);
    fetch(0);  check("f0", instr, 32'h00221821); check("f0_v", 32'(instr_valid), 32'd1);
    fetch(4);  check("f4", instr, 32'h00000000); check("f4_v", 32'(instr_valid), 32'd1);
    fetch(8);  check("f8", instr, 32'h8C430004);
    fetch(12); check("f12_err", 32'(addr_err), 32'd1); check("f12_v", 32'(instr_valid), 32'd0);
    fetch(2);  check("f2_err", 32'(addr_err), 32'd1);
    fetch(32'h80); check("f80_err", 32'(addr_err), 32'd1);

    // Stall holds, flush wins over stall.
    fetch(4);
    idle(); pc = 8; stall = 1; tick();
    check("stall_hold", instr, 32'h0); check("stall_v", 32'(instr_valid), 32'd1);
    idle(); pc = 8; stall = 1; flush = 1; tick();
    check("flush_v", 32'(instr_valid), 32'd0);

    // Fill all 32 words without load_last.
    idle(); reload = 1; tick();
    for (int i = 0; i < 32; i++) load_word(32'(i), 0);
    check("full_run", 32'(run), 32'd1);
    check("full_words", 32'(prog_words), 32'd32);
    idle(); load_valid = 1; load_data = 32'hDEAD_BEEF; pc = 124; tick();
    check("full_124", instr, 32'd31);
    fetch(0); check("full_0", instr, 32'd0);

    // Reload beats load_valid in the same cycle.
    idle(); reload = 1; load_valid = 1; load_data = 32'hBEEF_0000; tick();
    check("reload_run", 32'(run), 32'd0);
    check("reload_words", 32'(prog_words), 32'd0);
    load_word(32'h1234_5678, 1);
    fetch(0); check("reload_w0", instr, 32'h1234_5678);

    // Reset mid-load, then a fresh two-word load.
    idle(); reload = 1; tick();
    load_word(32'hAAAA_0001, 0);
    load_word(32'hAAAA_0002, 0);
    idle(); reset = 1; tick();
    check("midrst_words", 32'(prog_words), 32'd0);
    check("midrst_run", 32'(run), 32'd0);
    load_word(32'h5555_0000, 0);
    load_word(32'h5555_0001, 1);
    fetch(4); check("midrst_w1", instr, 32'h5555_0001);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      idle();
      reset      = ($urandom_range(0, 299) == 0);
      reload     = ($urandom_range(0, 79) == 0);
      load_valid = ($urandom_range(0, 1) == 1);
      load_last  = ($urandom_range(0, 7) == 0);
      load_data  = $urandom;
      stall      = ($urandom_range(0, 4) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 9))
        0:       pc = $urandom;
        1:       pc = 32'($urandom_range(0, 127));
        default: pc = 32'($urandom_range(0, 31)) * 4;
      endcase
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
